// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: shares one APB master port between NUM_REQ local requesters.
// A round-robin pick is made in IDLE, and the winner's command is latched. The
// block then runs SETUP/ACCESS on the bus and returns a one-cycle done pulse,
// an error flag and, for successful reads, the read data.
// A watchdog aborts an ACCESS phase once it has waited TIMEOUT cycles;
// TIMEOUT = 0 disables the watchdog.
//
// Ports:
//   pclk, preset_n          clock, asynchronous active-low reset
//   req_i/req_write_i       per-requester request level and direction
//   req_addr_i/req_wdata_i  packed per-requester address / write data
//   gnt_o                   one-hot owner during SETUP and ACCESS
//   done_o, err_o           one-cycle completion pulse, error qualifier
//   rdata_o                 data of the last successful read
//   psel_o .. pwdata_o      APB master outputs
//   prdata_i, pready_i,
//   pslverr_i               APB slave responses
module apb_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                        pclk,
  input  logic                        preset_n,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ-1:0]          req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]          gnt_o,
  output logic [NUM_REQ-1:0]          done_o,
  output logic                        err_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        psel_o,
  output logic                        penable_o,
  output logic                        pwrite_o,
  output logic [ADDR_W-1:0]           paddr_o,
  output logic [DATA_W-1:0]           pwdata_o,
  input  logic [DATA_W-1:0]           prdata_i,
  input  logic                        pready_i,
  input  logic                        pslverr_i
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e              r_state;
  logic [IdxW-1:0]     r_owner;
  logic [IdxW-1:0]     r_rr;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [CntW-1:0]     r_wait;
  logic [NUM_REQ-1:0]  r_done;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;

  state_e              w_state_nxt;
  logic [NUM_REQ-1:0]  w_masked;
  logic [IdxW:0]       w_scan;
  logic [IdxW-1:0]     w_pick;
  logic                w_pick_vld;
  logic                w_cmpl;
  logic                w_cmpl_err;
  logic                w_timeout;
  logic [NUM_REQ-1:0]  w_owner_oh;
  logic                w_busy;

  // Round-robin scan starting at r_rr. The requester whose done pulse is
  // showing this cycle is masked so that any other pending requester wins.
  always_comb begin
    w_masked   = req_i & ~r_done;
    w_pick_vld = 1'b0;
    w_pick     = '0;
    w_scan     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_scan = {1'b0, r_rr} + (IdxW+1)'(i);
      if (w_scan >= (IdxW+1)'(NUM_REQ)) begin
        w_scan = w_scan - (IdxW+1)'(NUM_REQ);
      end
      if (!w_pick_vld && w_masked[w_scan[IdxW-1:0]]) begin
        w_pick_vld = 1'b1;
        w_pick     = w_scan[IdxW-1:0];
      end
    end
  end

  always_comb begin
    w_owner_oh          = '0;
    w_owner_oh[r_owner] = 1'b1;
  end

  assign w_timeout = (TIMEOUT != 0) && (r_wait == CntW'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_cmpl      = 1'b0;
    w_cmpl_err  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_pick_vld) w_state_nxt = StSetup;
      end
      StSetup: begin
        w_state_nxt = StAccess;
      end
      StAccess: begin
        if (pready_i) begin
          w_cmpl      = 1'b1;
          w_cmpl_err  = pslverr_i;
          w_state_nxt = StIdle;
        end else if (w_timeout) begin
          w_cmpl      = 1'b1;
          w_cmpl_err  = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state <= StIdle;
      r_owner <= '0;
      r_rr    <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wait  <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= '0;
      r_err   <= 1'b0;
      if (r_state == StIdle && w_pick_vld) begin
        r_owner <= w_pick;
        r_write <= req_write_i[w_pick];
        r_addr  <= req_addr_i[w_pick*ADDR_W +: ADDR_W];
        r_wdata <= req_wdata_i[w_pick*DATA_W +: DATA_W];
      end
      if (r_state == StAccess) begin
        if (w_cmpl) begin
          r_wait <= '0;
          r_done <= w_owner_oh;
          r_err  <= w_cmpl_err;
          r_rr   <= (r_owner == IdxW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
          if (pready_i && !pslverr_i && !r_write) begin
            r_rdata <= prdata_i;
          end
        end else begin
          r_wait <= r_wait + 1'b1;
        end
      end
    end
  end

  // Bus outputs decode from state alone so reset drops them immediately.
  assign w_busy    = (r_state != StIdle);
  assign gnt_o     = w_busy ? w_owner_oh : '0;
  assign psel_o    = w_busy;
  assign penable_o = (r_state == StAccess);
  assign pwrite_o  = w_busy & r_write;
  assign paddr_o   = w_busy ? r_addr : '0;
  assign pwdata_o  = (w_busy && r_write) ? r_wdata : '0;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign rdata_o   = r_rdata;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// tb_apb_rr_arbiter: directed scenarios plus randomized transfers for the
// APB round-robin arbiter. Inputs are driven and outputs sampled on the
// falling clock edge.
module tb_apb_rr_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 16;

  logic                       pclk;
  logic                       preset_n;
  logic [NUM_REQ-1:0]         req_i;
  logic [NUM_REQ-1:0]         req_write_i;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i;
  logic [NUM_REQ*DATA_W-1:0]  req_wdata_i;
  logic [NUM_REQ-1:0]         gnt_o;
  logic [NUM_REQ-1:0]         done_o;
  logic                       err_o;
  logic [DATA_W-1:0]          rdata_o;
  logic                       psel_o;
  logic                       penable_o;
  logic                       pwrite_o;
  logic [ADDR_W-1:0]          paddr_o;
  logic [DATA_W-1:0]          pwdata_o;
  logic [DATA_W-1:0]          prdata_i;
  logic                       pready_i;
  logic                       pslverr_i;

  int checks = 0;
  int errors = 0;

  // Commands currently issued by each requester in the random test.
  logic                       mc_wr   [NUM_REQ];
  logic [ADDR_W-1:0]          mc_addr [NUM_REQ];
  logic [DATA_W-1:0]          mc_wd   [NUM_REQ];

  apb_rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk       (pclk),
    .preset_n   (preset_n),
    .req_i      (req_i),
    .req_write_i(req_write_i),
    .req_addr_i (req_addr_i),
    .req_wdata_i(req_wdata_i),
    .gnt_o      (gnt_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .rdata_o    (rdata_o),
    .psel_o     (psel_o),
    .penable_o  (penable_o),
    .pwrite_o   (pwrite_o),
    .paddr_o    (paddr_o),
    .pwdata_o   (pwdata_o),
    .prdata_i   (prdata_i),
    .pready_i   (pready_i),
    .pslverr_i  (pslverr_i)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic new_cmd(input int j);
    mc_wr[j]   = 1'($urandom_range(0, 1));
    mc_addr[j] = $urandom;
    mc_wd[j]   = $urandom;
    req_write_i[j]                   = mc_wr[j];
    req_addr_i[j*ADDR_W +: ADDR_W]   = mc_addr[j];
    req_wdata_i[j*DATA_W +: DATA_W]  = mc_wd[j];
    req_i[j]                         = 1'b1;
  endtask

  task automatic test_reset();
    preset_n = 1'b0;
    req_i = '1;
    tick();
    checks++;
    if ({gnt_o, done_o, err_o, psel_o, penable_o, pwrite_o} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got gnt=%b done=%b err=%b sel=%b en=%b wr=%b exp all 0",
               gnt_o, done_o, err_o, psel_o, penable_o, pwrite_o);
    end
    checks++;
    if ({rdata_o, paddr_o, pwdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h paddr=%h pwdata=%h exp 0",
               rdata_o, paddr_o, pwdata_o);
    end
    req_i = '0;
    preset_n = 1'b1;
    tick();
    checks++;
    if (psel_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got psel=%b exp 0", psel_o);
    end
  endtask

  task automatic test_single_read();
    req_write_i[0] = 1'b0;
    req_addr_i[31:0] = 32'hA000;
    req_i[0] = 1'b1;
    prdata_i = 32'h1234;
    pready_i = 1'b1;
    tick();
    checks++;
    if ({psel_o, penable_o, gnt_o, pwrite_o} !== {2'b10, 4'b0001, 1'b0} || paddr_o !== 32'hA000
        || pwdata_o !== '0) begin
      errors++;
      $display("FAIL rd_setup: got sel=%b en=%b gnt=%b wr=%b addr=%h wd=%h exp 1 0 0001 0 a000 0",
               psel_o, penable_o, gnt_o, pwrite_o, paddr_o, pwdata_o);
    end
    tick();
    checks++;
    if ({psel_o, penable_o} !== 2'b11) begin
      errors++;
      $display("FAIL rd_access: got sel/en=%b exp 11", {psel_o, penable_o});
    end
    tick();
    checks++;
    if (done_o !== 4'b0001 || err_o !== 1'b0 || rdata_o !== 32'h1234) begin
      errors++;
      $display("FAIL rd_done: got done=%b err=%b rdata=%h exp 0001 0 1234",
               done_o, err_o, rdata_o);
    end
    checks++;
    if ({psel_o, penable_o, gnt_o} !== '0) begin
      errors++;
      $display("FAIL rd_release: got sel=%b en=%b gnt=%b exp 0", psel_o, penable_o, gnt_o);
    end
    req_i[0] = 1'b0;
    pready_i = 1'b0;
    tick();
    checks++;
    if (done_o !== 4'b0000) begin
      errors++;
      $display("FAIL rd_pulse: got done=%b exp 0000", done_o);
    end
  endtask

  task automatic test_write_wait();
    int n;
    req_write_i[2] = 1'b1;
    req_addr_i[2*ADDR_W +: ADDR_W] = 32'hA004;
    req_wdata_i[2*DATA_W +: DATA_W] = 32'hDEAD;
    req_i[2] = 1'b1;
    pready_i = 1'b0;
    tick();
    checks++;
    if (gnt_o !== 4'b0100 || pwrite_o !== 1'b1 || paddr_o !== 32'hA004 || pwdata_o !== 32'hDEAD)
    begin
      errors++;
      $display("FAIL wr_setup: got gnt=%b wr=%b addr=%h wd=%h exp 0100 1 a004 dead",
               gnt_o, pwrite_o, paddr_o, pwdata_o);
    end
    // Requester changes its inputs after the grant; the bus must not follow.
    req_addr_i[2*ADDR_W +: ADDR_W] = '0;
    req_wdata_i[2*DATA_W +: DATA_W] = '0;
    req_write_i[2] = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done_o !== '0) break;
      if (penable_o === 1'b1) n++;
      if (n == 4) begin
        checks++;
        if (paddr_o !== 32'hA004 || pwdata_o !== 32'hDEAD || pwrite_o !== 1'b1) begin
          errors++;
          $display("FAIL wr_stable: got addr=%h wd=%h wr=%b exp a004 dead 1",
                   paddr_o, pwdata_o, pwrite_o);
        end
      end
      pready_i = (n == 4);
    end
    checks++;
    if (n !== 4 || done_o !== 4'b0100 || err_o !== 1'b0 || rdata_o !== 32'h1234) begin
      errors++;
      $display("FAIL wr_done: got access=%0d done=%b err=%b rdata=%h exp 4 0100 0 1234",
               n, done_o, err_o, rdata_o);
    end
    req_i[2] = 1'b0;
    pready_i = 1'b0;
    tick();
  endtask

  task automatic test_slverr();
    req_write_i[1] = 1'b0;
    req_addr_i[1*ADDR_W +: ADDR_W] = 32'hA008;
    req_i[1] = 1'b1;
    pready_i = 1'b1;
    pslverr_i = 1'b1;
    prdata_i = 32'hFFFF;
    tick();
    checks++;
    if (gnt_o !== 4'b0010) begin
      errors++;
      $display("FAIL se_gnt: got gnt=%b exp 0010", gnt_o);
    end
    tick();
    tick();
    checks++;
    if (done_o !== 4'b0010 || err_o !== 1'b1 || rdata_o !== 32'h1234) begin
      errors++;
      $display("FAIL se_done: got done=%b err=%b rdata=%h exp 0010 1 1234",
               done_o, err_o, rdata_o);
    end
    req_i[1] = 1'b0;
    pready_i = 1'b0;
    pslverr_i = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    req_write_i[3] = 1'b0;
    req_addr_i[3*ADDR_W +: ADDR_W] = 32'hA00C;
    req_write_i[0] = 1'b0;
    req_addr_i[31:0] = 32'hA010;
    req_i[3] = 1'b1;
    req_i[0] = 1'b1;
    pready_i = 1'b0;
    prdata_i = 32'h5555;
    tick();
    checks++;
    if (gnt_o !== 4'b1000) begin
      errors++;
      $display("FAIL to_gnt: got gnt=%b exp 1000", gnt_o);
    end
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done_o !== '0) break;
      if (penable_o === 1'b1) n++;
    end
    checks++;
    if (n !== TIMEOUT || done_o !== 4'b1000 || err_o !== 1'b1 || rdata_o !== 32'h1234
        || gnt_o !== '0) begin
      errors++;
      $display("FAIL to_done: got access=%0d done=%b err=%b rdata=%h gnt=%b exp %0d 1000 1 1234 0",
               n, done_o, err_o, rdata_o, gnt_o, TIMEOUT);
    end
    req_i[3] = 1'b0;
    pready_i = 1'b1;
    tick();
    checks++;
    if (gnt_o !== 4'b0001 || paddr_o !== 32'hA010) begin
      errors++;
      $display("FAIL to_next: got gnt=%b addr=%h exp 0001 a010", gnt_o, paddr_o);
    end
    tick();
    tick();
    checks++;
    if (done_o !== 4'b0001 || rdata_o !== 32'h5555) begin
      errors++;
      $display("FAIL to_next_done: got done=%b rdata=%h exp 0001 5555", done_o, rdata_o);
    end
    req_i[0] = 1'b0;
    pready_i = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    int ng;
    logic [NUM_REQ-1:0] prev_done;
    logic [NUM_REQ-1:0] exp_oh;
    preset_n = 1'b0;
    req_write_i = '0;
    req_i = '1;
    pready_i = 1'b1;
    prdata_i = '0;
    tick();
    preset_n = 1'b1;
    ng = 0;
    prev_done = '0;
    for (int c = 0; c < 30 && ng < 5; c++) begin
      tick();
      checks++;
      if ((gnt_o & done_o) !== '0 && (gnt_o !== '0 || done_o !== '0)) begin
        errors++;
        $display("FAIL ct_overlap: got gnt=%b done=%b exp disjoint", gnt_o, done_o);
      end
      if (psel_o === 1'b1 && penable_o === 1'b0) begin
        exp_oh = '0;
        exp_oh[ng % NUM_REQ] = 1'b1;
        checks++;
        if (gnt_o !== exp_oh || (ng > 0 && prev_done === '0)) begin
          errors++;
          $display("FAIL ct_order: grant %0d got gnt=%b prev_done=%b exp %b after done",
                   ng, gnt_o, prev_done, exp_oh);
        end
        ng++;
      end
      prev_done = done_o;
    end
    checks++;
    if (ng !== 5) begin
      errors++;
      $display("FAIL ct_count: got %0d grants exp 5", ng);
    end
    preset_n = 1'b0;
    req_i = '0;
    pready_i = 1'b0;
    tick();
    preset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    req_write_i[2] = 1'b1;
    req_i[2] = 1'b1;
    pready_i = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (done_o !== 4'b0100) begin
      errors++;
      $display("FAIL rm_pre: got done=%b exp 0100", done_o);
    end
    req_i[2] = 1'b0;
    pready_i = 1'b0;
    req_write_i[1] = 1'b0;
    req_i[1] = 1'b1;
    tick();
    checks++;
    if (gnt_o !== 4'b0010) begin
      errors++;
      $display("FAIL rm_gnt: got gnt=%b exp 0010", gnt_o);
    end
    tick();
    tick();
    preset_n = 1'b0;
    req_i = 4'b1001;
    #1;
    checks++;
    if ({psel_o, penable_o, gnt_o, done_o, paddr_o} !== '0) begin
      errors++;
      $display("FAIL rm_async: got sel=%b en=%b gnt=%b done=%b addr=%h exp 0",
               psel_o, penable_o, gnt_o, done_o, paddr_o);
    end
    tick();
    tick();
    preset_n = 1'b1;
    pready_i = 1'b1;
    checks++;
    if (done_o !== '0) begin
      errors++;
      $display("FAIL rm_nodone: got done=%b exp 0000", done_o);
    end
    tick();
    checks++;
    if (gnt_o !== 4'b0001) begin
      errors++;
      $display("FAIL rm_rr: got gnt=%b exp 0001", gnt_o);
    end
    tick();
    tick();
    checks++;
    if (done_o !== 4'b0001) begin
      errors++;
      $display("FAIL rm_done: got done=%b exp 0001", done_o);
    end
    req_i = '0;
    pready_i = 1'b0;
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] pend, done_mask, masked, exp_oh;
    logic [DATA_W-1:0]  m_rdata, pd;
    int                 m_rr, k, w, nacc;
    bit                 to, se;
    preset_n = 1'b0;
    req_i = '0;
    pready_i = 1'b0;
    pslverr_i = 1'b0;
    tick();
    preset_n = 1'b1;
    tick();
    pend = '0;
    done_mask = '0;
    m_rr = 0;
    m_rdata = '0;
    for (int t = 0; t < 60; t++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!pend[j] && $urandom_range(0, 2) == 0) begin
          new_cmd(j);
          pend[j] = 1'b1;
        end
      end
      if (pend == '0) begin
        k = $urandom_range(0, NUM_REQ - 1);
        new_cmd(k);
        pend[k] = 1'b1;
      end
      masked = pend & ~done_mask;
      // Only the just-completed requester is asking: it must sit out one cycle.
      while (masked == '0) begin
        tick();
        checks++;
        if (psel_o !== 1'b0) begin
          errors++;
          $display("FAIL rnd_mask: got psel=%b exp 0", psel_o);
        end
        done_mask = '0;
        masked = pend;
      end
      k = -1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (k < 0 && masked[(m_rr + i) % NUM_REQ]) k = (m_rr + i) % NUM_REQ;
      end
      exp_oh = '0;
      exp_oh[k] = 1'b1;
      tick();
      checks++;
      if (gnt_o !== exp_oh || {psel_o, penable_o} !== 2'b10 || done_o !== '0) begin
        errors++;
        $display("FAIL rnd_gnt: got gnt=%b sel/en=%b done=%b exp %b 10 0000",
                 gnt_o, {psel_o, penable_o}, done_o, exp_oh);
      end
      checks++;
      if (paddr_o !== mc_addr[k] || pwrite_o !== mc_wr[k]
          || pwdata_o !== (mc_wr[k] ? mc_wd[k] : '0)) begin
        errors++;
        $display("FAIL rnd_cmd: got addr=%h wr=%b wd=%h exp %h %b %h", paddr_o, pwrite_o,
                 pwdata_o, mc_addr[k], mc_wr[k], mc_wr[k] ? mc_wd[k] : '0);
      end
      req_addr_i[k*ADDR_W +: ADDR_W] = $urandom;
      req_wdata_i[k*DATA_W +: DATA_W] = $urandom;
      req_write_i[k] = ~mc_wr[k];
      if ($urandom_range(0, 3) == 0) req_i[k] = 1'b0;
      to = ($urandom_range(0, 9) == 0);
      w = $urandom_range(0, 3);
      se = ($urandom_range(0, 3) == 0);
      pd = $urandom;
      nacc = to ? TIMEOUT : w + 1;
      tick();
      for (int a = 0; a < nacc; a++) begin
        checks++;
        if ({psel_o, penable_o} !== 2'b11 || gnt_o !== exp_oh || done_o !== '0
            || paddr_o !== mc_addr[k] || pwdata_o !== (mc_wr[k] ? mc_wd[k] : '0)) begin
          errors++;
          $display("FAIL rnd_access: cycle %0d got sel/en=%b gnt=%b done=%b addr=%h wd=%h",
                   a, {psel_o, penable_o}, gnt_o, done_o, paddr_o, pwdata_o);
        end
        if (!to && a == w) begin
          pready_i = 1'b1;
          pslverr_i = se;
          prdata_i = pd;
        end else begin
          pready_i = 1'b0;
          pslverr_i = 1'($urandom_range(0, 1));
          prdata_i = $urandom;
        end
        tick();
      end
      if (!to && !se && !mc_wr[k]) m_rdata = pd;
      checks++;
      if (done_o !== exp_oh || err_o !== (to || se) || rdata_o !== m_rdata) begin
        errors++;
        $display("FAIL rnd_done: got done=%b err=%b rdata=%h exp %b %b %h",
                 done_o, err_o, rdata_o, exp_oh, to || se, m_rdata);
      end
      checks++;
      if ({psel_o, penable_o, pwrite_o, gnt_o, paddr_o, pwdata_o} !== '0) begin
        errors++;
        $display("FAIL rnd_idle: got sel=%b en=%b wr=%b gnt=%b addr=%h wd=%h exp 0",
                 psel_o, penable_o, pwrite_o, gnt_o, paddr_o, pwdata_o);
      end
      pready_i = 1'b0;
      pslverr_i = 1'b0;
      req_i[k] = 1'b0;
      pend[k] = 1'b0;
      done_mask = exp_oh;
      m_rr = (k + 1) % NUM_REQ;
    end
  endtask

  initial begin
    preset_n = 1'b0;
    req_i = '0;
    req_write_i = '0;
    req_addr_i = '0;
    req_wdata_i = '0;
    prdata_i = '0;
    pready_i = 1'b0;
    pslverr_i = 1'b0;
    test_reset();
    test_single_read();
    test_write_wait();
    test_slverr();
    test_timeout();
    test_contention();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
